freq_step_gen: RTL and testbench
================================

FREQ_STEP_GEN -- requirements
Module: freq_step_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of divisor and counters.
REQ-002 SHALL have parameter BASE_DIV, default 2273: divisor at step 0 (nominal 22 kHz/11 kHz pair from 50 MHz).
REQ-003 SHALL have parameter STEP_DIV, default 50: divisor change per step.
REQ-004 SHALL have parameter NSTEPS, default 31: max steps in each direction from step 0.
REQ-005 SHALL have port clk, input, 1: sole clock; all state on posedge clk.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port fast, input, 1: speed-up request, level from pushbutton.
REQ-008 SHALL have port slow, input, 1: slow-down request, level from pushbutton.
REQ-009 SHALL have port div_count, output, WIDTH: current full-period divisor.
REQ-010 SHALL have port step, output, $clog2(NSTEPS+1)+1, two's complement: current step, -NSTEPS..+NSTEPS.
REQ-011 SHALL have port new_sig, output, 1: square wave toggling every div_count/2 cycles.
REQ-012 SHALL have port slow_sig, output, 1: square wave toggling every div_count cycles.
REQ-013 SHALL have port new_tick, output, 1: one-cycle pulse on each new_sig toggle.
REQ-014 SHALL have port slow_tick, output, 1: one-cycle pulse on each slow_sig toggle.
REQ-015 SHALL have ports at_fast_lim and at_slow_lim, outputs, 1 each: step == +NSTEPS and step == -NSTEPS respectively.

Function
REQ-016 SHALL compute div_count = BASE_DIV - step*STEP_DIV, registered, valid in the same cycle as step.
REQ-017 SHALL register fast and slow each cycle; a press event is a 0->1 transition between the registered value and the current input.
REQ-018 SHALL increment step by 1 on a fast event alone; held levels SHALL NOT produce further events.
REQ-019 SHALL decrement step by 1 on a slow event alone.
REQ-020 SHALL leave step unchanged when fast and slow events occur in the same cycle.
REQ-021 SHALL saturate: a fast event at +NSTEPS or a slow event at -NSTEPS leaves step unchanged, with no wrap.
REQ-022 SHALL run half counter h: if h >= div_count/2 - 1 (integer divide), then h <= 0, new_sig toggles, and new_tick = 1 next cycle; otherwise h <= h + 1 and new_tick = 0.
REQ-023 SHALL run full counter f by the same rule with threshold div_count - 1, driving slow_sig and slow_tick.
REQ-024 SHALL apply a step change to the counters from the cycle after the event; counters are not cleared.
REQ-025 SHALL, if a counter already exceeds the new threshold, wrap on the next cycle (>= compare); no overrun past 2^WIDTH.
REQ-026 SHALL set new_tick and slow_tick high in the same cycle that the corresponding square wave changes level.
REQ-027 SHALL require, at elaboration, BASE_DIV - NSTEPS*STEP_DIV >= 4 and BASE_DIV + NSTEPS*STEP_DIV < 2^WIDTH; violation is a fatal error.
REQ-028 SHALL derive at_fast_lim and at_slow_lim combinationally from registered step.

Reset
REQ-029 SHALL, while reset = 1 at posedge clk, set step = 0, div_count = BASE_DIV, h = f = 0, new_sig = slow_sig = 0, new_tick = slow_tick = 0.
REQ-030 SHALL, during reset, load the registered fast/slow values from the current inputs, so a button held through reset release produces no event.
REQ-031 SHALL give reset priority over any same-cycle fast/slow event.

Verification (BASE_DIV=20, STEP_DIV=2, NSTEPS=3, WIDTH=8)
REQ-032 SHALL cover: reset, then idle for 100 cycles -> div_count = 20; new_sig toggles every 10 cycles; slow_sig toggles every 20 cycles; each toggle has a coincident one-cycle tick.
REQ-033 SHALL cover: fast held high for 5 cycles -> exactly one step, step = 1, div_count = 18; new_sig period becomes 18 cycles.
REQ-034 SHALL cover: 5 separate fast presses from step 0 -> step saturates at 3, div_count = 14, at_fast_lim = 1; then 7 slow presses -> step = -3, div_count = 26, at_slow_lim = 1.
REQ-035 SHALL cover: fast and slow rising in the same cycle -> step and div_count unchanged.
REQ-036 SHALL cover: with step = -3 and h = 12, a fast event (div_count 26 -> 24, threshold 11) -> h wraps to 0 and new_sig toggles one cycle after div_count updates.
REQ-037 SHALL cover: reset asserted mid-run with fast held high -> all outputs return to reset values; no step change after reset release until fast is released and pressed again.

Source files
------------

// File: rtl/freq_step_gen.sv
// Stepped frequency generator: pushbutton-driven divisor steps drive two square waves
// (half-period div_count/2 and div_count) with coincident one-cycle toggle ticks.
module freq_step_gen #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BASE_DIV = 2273,
    parameter int unsigned STEP_DIV = 50,
    parameter int unsigned NSTEPS   = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fast,
    input  logic                          slow,
    output logic [WIDTH-1:0]              div_count,
    output logic [$clog2(NSTEPS+1):0]     step,
    output logic                          new_sig,
    output logic                          slow_sig,
    output logic                          new_tick,
    output logic                          slow_tick,
    output logic                          at_fast_lim,
    output logic                          at_slow_lim
);

    localparam int unsigned SW = $clog2(NSTEPS + 1) + 1;

    localparam longint MinDiv = longint'(BASE_DIV) - longint'(NSTEPS) * longint'(STEP_DIV);
    localparam longint MaxDiv = longint'(BASE_DIV) + longint'(NSTEPS) * longint'(STEP_DIV);

    generate
        if (MinDiv < 4 || MaxDiv >= (longint'(1) << WIDTH)) begin : g_bad_params
            $fatal(1, "freq_step_gen: divisor range does not fit in [4, 2^WIDTH)");
        end
    endgenerate

    localparam logic signed [SW-1:0] StepMax = SW'(NSTEPS);
    localparam logic signed [SW-1:0] StepMin = -StepMax;

    logic                    fast_q, slow_q;
    logic                    fast_evt, slow_evt;
    logic signed [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0]        step_ext;
    logic [WIDTH-1:0]        div_q, div_d;
    logic [WIDTH-1:0]        h_q, h_d, f_q, f_d;
    logic [WIDTH-1:0]        half_thr, full_thr;
    logic                    new_sig_q, new_sig_d, slow_sig_q, slow_sig_d;
    logic                    new_tick_q, new_tick_d, slow_tick_q, slow_tick_d;

    assign fast_evt = fast & ~fast_q;
    assign slow_evt = slow & ~slow_q;

    // Simultaneous presses cancel; saturate at the limits instead of wrapping.
    always_comb begin
        step_d = step_q;
        if (fast_evt && !slow_evt && step_q != StepMax) begin
            step_d = step_q + SW'(1);
        end else if (slow_evt && !fast_evt && step_q != StepMin) begin
            step_d = step_q - SW'(1);
        end
    end

    // Sign-extended step, so the modular product gives BASE_DIV - step*STEP_DIV.
    assign step_ext = WIDTH'(step_d);
    assign div_d    = WIDTH'(BASE_DIV) - step_ext * WIDTH'(STEP_DIV);

    assign half_thr = (div_q >> 1) - WIDTH'(1);
    assign full_thr = div_q - WIDTH'(1);

    // >= compare lets a counter above a freshly lowered threshold wrap at once.
    always_comb begin
        h_d         = h_q + WIDTH'(1);
        new_sig_d   = new_sig_q;
        new_tick_d  = 1'b0;
        if (h_q >= half_thr) begin
            h_d        = '0;
            new_sig_d  = ~new_sig_q;
            new_tick_d = 1'b1;
        end
    end

    always_comb begin
        f_d          = f_q + WIDTH'(1);
        slow_sig_d   = slow_sig_q;
        slow_tick_d  = 1'b0;
        if (f_q >= full_thr) begin
            f_d         = '0;
            slow_sig_d  = ~slow_sig_q;
            slow_tick_d = 1'b1;
        end
    end

    // Button history loads during reset too, so a button held through release is not an event.
    always_ff @(posedge clk) begin
        fast_q <= fast;
        slow_q <= slow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q      <= '0;
            div_q       <= WIDTH'(BASE_DIV);
            h_q         <= '0;
            f_q         <= '0;
            new_sig_q   <= 1'b0;
            slow_sig_q  <= 1'b0;
            new_tick_q  <= 1'b0;
            slow_tick_q <= 1'b0;
        end else begin
            step_q      <= step_d;
            div_q       <= div_d;
            h_q         <= h_d;
            f_q         <= f_d;
            new_sig_q   <= new_sig_d;
            slow_sig_q  <= slow_sig_d;
            new_tick_q  <= new_tick_d;
            slow_tick_q <= slow_tick_d;
        end
    end

    assign div_count   = div_q;
    assign step        = step_q;
    assign new_sig     = new_sig_q;
    assign slow_sig    = slow_sig_q;
    assign new_tick    = new_tick_q;
    assign slow_tick   = slow_tick_q;
    assign at_fast_lim = (step_q == StepMax);
    assign at_slow_lim = (step_q == StepMin);

endmodule

// File: tb/tb_freq_step_gen.sv
// Bench for freq_step_gen: integer reference model checked every cycle, directed scenarios
// with literal expectations, then randomized button/reset traffic.
module tb_freq_step_gen;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned BASE_DIV = 20;
    localparam int unsigned STEP_DIV = 2;
    localparam int unsigned NSTEPS   = 3;
    localparam int unsigned SW       = $clog2(NSTEPS + 1) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              fast = 1'b0;
    logic              slow = 1'b0;
    logic [WIDTH-1:0]  div_count;
    logic [SW-1:0]     step;
    logic              new_sig, slow_sig, new_tick, slow_tick, at_fast_lim, at_slow_lim;

    int checks = 0;
    int errors = 0;

    freq_step_gen #(
        .WIDTH    (WIDTH),
        .BASE_DIV (BASE_DIV),
        .STEP_DIV (STEP_DIV),
        .NSTEPS   (NSTEPS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fast        (fast),
        .slow        (slow),
        .div_count   (div_count),
        .step        (step),
        .new_sig     (new_sig),
        .slow_sig    (slow_sig),
        .new_tick    (new_tick),
        .slow_tick   (slow_tick),
        .at_fast_lim (at_fast_lim),
        .at_slow_lim (at_slow_lim)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers, updated with the rules of the datasheet.
    bit m_valid = 1'b0;
    int m_step, m_div, m_h, m_f;
    bit m_ns, m_ss, m_nt, m_st, m_fprev, m_sprev;

    always @(posedge clk) begin
        bit fe, se;
        if (reset) begin
            m_valid = 1'b1;
            m_step = 0; m_div = BASE_DIV; m_h = 0; m_f = 0;
            m_ns = 0; m_ss = 0; m_nt = 0; m_st = 0;
        end else begin
            fe = fast && !m_fprev;
            se = slow && !m_sprev;
            m_nt = (m_h >= m_div / 2 - 1);
            if (m_nt) begin m_h = 0; m_ns = !m_ns; end else m_h++;
            m_st = (m_f >= m_div - 1);
            if (m_st) begin m_f = 0; m_ss = !m_ss; end else m_f++;
            if (fe && !se && m_step < int'(NSTEPS)) m_step++;
            if (se && !fe && m_step > -int'(NSTEPS)) m_step--;
            m_div = BASE_DIV - m_step * STEP_DIV;
        end
        m_fprev = fast;
        m_sprev = slow;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("div_count", int'(div_count), m_div);
            chk("step", int'($signed(step)), m_step);
            chk("new_sig", int'(new_sig), int'(m_ns));
            chk("slow_sig", int'(slow_sig), int'(m_ss));
            chk("new_tick", int'(new_tick), int'(m_nt));
            chk("slow_tick", int'(slow_tick), int'(m_st));
            chk("at_fast_lim", int'(at_fast_lim), int'(m_step == int'(NSTEPS)));
            chk("at_slow_lim", int'(at_slow_lim), int'(m_step == -int'(NSTEPS)));
        end
    end

    // Cycles until new_sig / slow_sig next changes; a missing toggle is a failure.
    task automatic wait_new(output int n);
        logic s;
        s = new_sig;
        n = 0;
        do begin @(negedge clk); n++; end while (new_sig == s && n < 200);
        if (n >= 200) chk("new_sig_timeout", n, 0);
    endtask

    task automatic wait_slow(output int n);
        logic s;
        s = slow_sig;
        n = 0;
        do begin @(negedge clk); n++; end while (slow_sig == s && n < 200);
        if (n >= 200) chk("slow_sig_timeout", n, 0);
    endtask

    task automatic press_fast();
        fast = 1'b1; @(negedge clk); fast = 1'b0; @(negedge clk);
    endtask

    task automatic press_slow();
        slow = 1'b1; @(negedge clk); slow = 1'b0; @(negedge clk);
    endtask

    initial begin
        int n, n1, n2;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_step", int'($signed(step)), 0);
        chk("rst_div", int'(div_count), 20);
        chk("rst_new_sig", int'(new_sig), 0);
        chk("rst_slow_tick", int'(slow_tick), 0);

        // Idle: half-period 10 on new_sig, 20 on slow_sig, ticks coincide.
        wait_new(n);
        chk("idle_new_tick", int'(new_tick), 1);
        wait_new(n);
        chk("idle_new_half", n, 10);
        wait_slow(n);
        chk("idle_slow_tick", int'(slow_tick), 1);
        wait_slow(n);
        chk("idle_slow_half", n, 20);
        repeat (40) @(negedge clk);
        chk("idle_div", int'(div_count), 20);

        // Held fast gives a single step.
        fast = 1'b1;
        repeat (5) @(negedge clk);
        fast = 1'b0;
        @(negedge clk);
        chk("hold_step", int'($signed(step)), 1);
        chk("hold_div", int'(div_count), 18);
        wait_new(n);
        wait_new(n1);
        wait_new(n2);
        chk("step1_new_period", n1 + n2, 18);

        repeat (5) press_fast();
        chk("sat_fast_step", int'($signed(step)), 3);
        chk("sat_fast_div", int'(div_count), 14);
        chk("sat_fast_lim", int'(at_fast_lim), 1);
        repeat (7) press_slow();
        chk("sat_slow_step", int'($signed(step)), -3);
        chk("sat_slow_div", int'(div_count), 26);
        chk("sat_slow_lim", int'(at_slow_lim), 1);

        // h above a freshly lowered threshold wraps one cycle after div_count changes.
        wait_new(n);
        repeat (11) @(negedge clk);
        fast = 1'b1;
        @(negedge clk);
        fast = 1'b0;
        chk("wrap_div", int'(div_count), 24);
        chk("wrap_tick_early", int'(new_tick), 0);
        @(negedge clk);
        chk("wrap_tick", int'(new_tick), 1);

        // Simultaneous presses cancel.
        fast = 1'b1; slow = 1'b1;
        @(negedge clk);
        fast = 1'b0; slow = 1'b0;
        @(negedge clk);
        chk("both_step", int'($signed(step)), -2);
        chk("both_div", int'(div_count), 24);

        // Reset mid-run with fast held: no event until re-press.
        fast = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_step", int'($signed(step)), 0);
        chk("mid_rst_div", int'(div_count), 20);
        chk("mid_rst_slow_sig", int'(slow_sig), 0);
        chk("mid_rst_new_tick", int'(new_tick), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_through_rst", int'($signed(step)), 0);
        fast = 1'b0;
        @(negedge clk);
        press_fast();
        chk("repress_step", int'($signed(step)), 1);

        // Random buttons and occasional reset, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            fast  = ($urandom_range(0, 5) == 0);
            slow  = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset = 1'b0; fast = 1'b0; slow = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
